// File: rtl/brightness_chunk_scheduler.sv
// brightness_chunk_scheduler
//
// Sequences a brightness-filter job over a matrix_size x matrix_size image
// held in single-port synchronous RAM. The image is processed in chunks of
// chunk_size pixels. For each chunk the block reads the pixels, loads them
// lane by lane into the systolic brightness array, fires the array, waits
// for it to finish, then writes the lane results to the output region at
// wr_base.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   start             job request, honoured only when idle
//   cfg_offset/mode   brightness offset and direction, latched on start
//   mem_rd_*          RAM read port (data returns one cycle after mem_rd_en)
//   arr_offset/mode   latched configuration, held for the whole job
//   arr_load*         lane load strobe, lane index and lane pixel
//   arr_go            one-cycle compute pulse
//   arr_done          array result ready (level or pulse)
//   arr_res_idx/data  result lane select and combinational lane result
//   mem_wr_*          RAM write port
//   busy, done        job in progress / one-cycle job-complete pulse
//   chunk_idx         index of the chunk currently being processed
//
// Strobe protocol: every strobe (mem_rd_en, arr_load, arr_go, mem_wr_en)
// is a single-cycle command with no back-pressure; the only flow control is
// arr_done, which is sampled in WAIT and releases the write-back. Reads and
// writes never share a cycle.
module brightness_chunk_scheduler #(
    parameter int addr_width  = 8,
    parameter int data_width  = 8,
    parameter int chunk_size  = 4,
    parameter int matrix_size = 8,
    parameter int wr_base     = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [data_width-1:0] cfg_offset,
    input  logic                  cfg_mode,
    output logic                  mem_rd_en,
    output logic [addr_width-1:0] mem_rd_addr,
    input  logic [data_width-1:0] mem_rd_data,
    output logic [data_width-1:0] arr_offset,
    output logic                  arr_mode,
    output logic                  arr_load,
    output logic [((chunk_size > 1) ? $clog2(chunk_size) : 1)-1:0] arr_load_idx,
    output logic [data_width-1:0] arr_load_data,
    output logic                  arr_go,
    input  logic                  arr_done,
    output logic [((chunk_size > 1) ? $clog2(chunk_size) : 1)-1:0] arr_res_idx,
    input  logic [data_width-1:0] arr_res_data,
    output logic                  mem_wr_en,
    output logic [addr_width-1:0] mem_wr_addr,
    output logic [data_width-1:0] mem_wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [addr_width-1:0] chunk_idx
);

    localparam int lane_w = (chunk_size > 1) ? $clog2(chunk_size) : 1;
    localparam int pixels = matrix_size * matrix_size;

    generate
        if (chunk_size < 1 || (chunk_size & (chunk_size - 1)) != 0) begin : g_bad_chunk
            $error("chunk_size must be a power of two and at least 1");
        end
        if ((pixels % chunk_size) != 0 || longint'(pixels) > (64'd1 << addr_width)) begin : g_bad_size
            $error("image must split into whole chunks and fit the address space");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LOAD_TAIL,
        S_FIRE,
        S_WAIT,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [addr_width-1:0]   base_q, base_d;
    logic [lane_w-1:0]       k_q, k_d;
    logic [addr_width-1:0]   chunk_q, chunk_d;
    logic [data_width-1:0]   offset_q, offset_d;
    logic                    mode_q, mode_d;

    logic                    k_last;
    logic                    image_last;

    assign k_last = (k_q == lane_w'(chunk_size - 1));
    // Widened by one bit so an image filling the whole address space ends cleanly.
    assign image_last = (({1'b0, base_q} + (addr_width + 1)'(chunk_size)) ==
                         (addr_width + 1)'(pixels));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            k_q      <= '0;
            chunk_q  <= '0;
            offset_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            k_q      <= k_d;
            chunk_q  <= chunk_d;
            offset_q <= offset_d;
            mode_q   <= mode_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        k_d           = k_q;
        chunk_d       = chunk_q;
        offset_d      = offset_q;
        mode_d        = mode_q;
        mem_rd_en     = 1'b0;
        mem_rd_addr   = '0;
        arr_load      = 1'b0;
        arr_load_idx  = '0;
        arr_load_data = '0;
        arr_go        = 1'b0;
        arr_res_idx   = '0;
        mem_wr_en     = 1'b0;
        mem_wr_addr   = '0;
        mem_wr_data   = '0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    offset_d = cfg_offset;
                    mode_d   = cfg_mode;
                    base_d   = '0;
                    chunk_d  = '0;
                    k_d      = '0;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                busy        = 1'b1;
                mem_rd_en   = 1'b1;
                mem_rd_addr = base_q + addr_width'(k_q);
                // Read data lags the strobe by one cycle, so lane k-1 is
                // loaded while lane k is being read. The RAM output is
                // already registered, so it is forwarded as-is.
                if (k_q != '0) begin
                    arr_load      = 1'b1;
                    arr_load_idx  = k_q - lane_w'(1);
                    arr_load_data = mem_rd_data;
                end
                if (k_last) begin
                    state_d = S_LOAD_TAIL;
                end else begin
                    k_d = k_q + lane_w'(1);
                end
            end
            S_LOAD_TAIL: begin
                // k still holds the last lane from the final read.
                busy          = 1'b1;
                arr_load      = 1'b1;
                arr_load_idx  = k_q;
                arr_load_data = mem_rd_data;
                state_d       = S_FIRE;
            end
            S_FIRE: begin
                busy    = 1'b1;
                arr_go  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (arr_done) begin
                    k_d     = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                busy        = 1'b1;
                arr_res_idx = k_q;
                mem_wr_en   = 1'b1;
                mem_wr_addr = addr_width'(wr_base) + base_q + addr_width'(k_q);
                mem_wr_data = arr_res_data;
                if (k_last) begin
                    state_d = S_NEXT;
                end else begin
                    k_d = k_q + lane_w'(1);
                end
            end
            S_NEXT: begin
                busy = 1'b1;
                if (image_last) begin
                    state_d = S_DONE;
                end else begin
                    base_d  = base_q + addr_width'(chunk_size);
                    chunk_d = chunk_q + addr_width'(1);
                    k_d     = '0;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign arr_offset = offset_q;
    assign arr_mode   = mode_q;
    assign chunk_idx  = chunk_q;

endmodule

// File: tb/tb_brightness_chunk_scheduler.sv
// tb_brightness_chunk_scheduler
//
// Directed bench for brightness_chunk_scheduler with default parameters
// (8x8 image, 4-pixel chunks, output region at 128). Surrounds the
// scheduler with a synchronous RAM holding RAM[i]=i and a saturating
// brightness-array model whose done flag rises a fixed number of cycles
// after arr_go. Every write is checked against an expected queue built from
// the job configuration.
module tb_brightness_chunk_scheduler;

    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int CS   = 4;
    localparam int MS   = 8;
    localparam int WB   = 128;
    localparam int NPIX = MS * MS;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start;
    logic [DW-1:0] cfg_offset;
    logic          cfg_mode;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] arr_offset;
    logic          arr_mode;
    logic          arr_load;
    logic [1:0]    arr_load_idx;
    logic [DW-1:0] arr_load_data;
    logic          arr_go;
    logic          arr_done;
    logic [1:0]    arr_res_idx;
    logic [DW-1:0] arr_res_data;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          busy;
    logic          done;
    logic [AW-1:0] chunk_idx;

    brightness_chunk_scheduler #(
        .addr_width (AW),
        .data_width (DW),
        .chunk_size (CS),
        .matrix_size(MS),
        .wr_base    (WB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_offset   (cfg_offset),
        .cfg_mode     (cfg_mode),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .arr_offset   (arr_offset),
        .arr_mode     (arr_mode),
        .arr_load     (arr_load),
        .arr_load_idx (arr_load_idx),
        .arr_load_data(arr_load_data),
        .arr_go       (arr_go),
        .arr_done     (arr_done),
        .arr_res_idx  (arr_res_idx),
        .arr_res_data (arr_res_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .busy         (busy),
        .done         (done),
        .chunk_idx    (chunk_idx)
    );

    // every DUT output in one vector, for the all-zero checks
    logic [63:0] outs_all;
    assign outs_all = {5'd0, mem_rd_en, mem_rd_addr, arr_offset, arr_mode, arr_load,
                       arr_load_idx, arr_load_data, arr_go, arr_res_idx, mem_wr_en,
                       mem_wr_addr, mem_wr_data, busy, done, chunk_idx};

    // checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_fn(input int p, input int off, input logic mode);
        int r;
        r = mode ? (p - off) : (p + off);
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return 8'(r);
    endfunction

    // RAM model: synchronous read, one cycle latency
    logic [7:0] ram [0:255];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = (i < 128) ? 8'(i) : 8'h00;
    end
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    end

    // brightness array model
    logic [7:0] lanes [0:CS-1];
    logic [7:0] res   [0:CS-1];
    int         dcnt = 0;
    logic       stall_en = 1'b0;
    logic       glitch_en = 1'b0;
    always @(posedge clk) begin
        if (arr_load) lanes[arr_load_idx] <= arr_load_data;
        if (arr_go) begin
            for (int i = 0; i < CS; i++) res[i] <= pix_fn(int'(lanes[i]), int'(arr_offset), arr_mode);
            dcnt <= (stall_en && chunk_idx == 8'd5) ? 53 : 3;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
        end
    end
    assign arr_res_data = res[arr_res_idx];
    // glitch_en also raises arr_done during FIRE, which must be ignored
    assign arr_done = (dcnt == 1) || (glitch_en && arr_go);

    // scoreboard and monitor
    logic [15:0] exp_q [$];
    logic [15:0] exp_w;
    int          rd_exp;
    int          busy_cnt;
    int          go_cnt;
    int          done_cnt;
    int          overlap;
    logic        prev_rd_en;
    logic [7:0]  prev_rd_addr;

    always @(negedge clk) begin
        if (rst) begin
            if (mem_rd_en) begin
                check_eq("rd_addr", 64'(mem_rd_addr), 64'(rd_exp));
                rd_exp++;
            end
            // a load must follow a read of the same lane; RAM[i]=i
            if (arr_load)
                check_eq("load", {prev_rd_en, arr_load_idx, arr_load_data},
                         {1'b1, prev_rd_addr[1:0], prev_rd_addr});
            if (mem_wr_en) begin
                exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
                check_eq("wr", {mem_wr_addr, mem_wr_data}, 64'(exp_w));
            end
            if (mem_rd_en && mem_wr_en) overlap++;
            if (busy) busy_cnt++;
            if (arr_go) go_cnt++;
            if (done) done_cnt++;
            prev_rd_en   = mem_rd_en;
            prev_rd_addr = mem_rd_addr;
        end
    end

    // driver tasks
    task automatic start_job(input logic [7:0] off, input logic m);
        @(negedge clk);
        cfg_offset = off;
        cfg_mode   = m;
        start      = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) exp_q.push_back({8'(WB + i), pix_fn(i, int'(off), m)});
        rd_exp     = 0;
        busy_cnt   = 0;
        go_cnt     = 0;
        done_cnt   = 0;
        overlap    = 0;
        prev_rd_en = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while (!done && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", 64'(done), 64'd1);
    endtask

    task automatic end_job(input int exp_busy);
        @(negedge clk);
        check_eq("idle_busy", 64'(busy), 64'd0);
        check_eq("done_one_cycle", 64'(done), 64'd0);
        check_eq("done_count", 64'(done_cnt), 64'd1);
        check_eq("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        check_eq("go_count", 64'(go_cnt), 64'd16);
        check_eq("rd_wr_overlap", 64'(overlap), 64'd0);
        check_eq("reads_total", 64'(rd_exp), 64'(NPIX));
        check_eq("writes_left", 64'(exp_q.size()), 64'd0);
        check_eq("chunk_idx_end", 64'(chunk_idx), 64'd15);
    endtask

    initial begin
        logic found;
        int   n;

        // reset held with start asserted: nothing may move
        rst        = 1'b0;
        start      = 1'b1;
        cfg_offset = 8'hAA;
        cfg_mode   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("reset_outs", outs_all, 64'd0);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("idle_outs", outs_all, 64'd0);

        // full job, brighten by 0x10, 14 cycles per chunk
        start_job(8'h10, 1'b0);
        wait_done(400);
        end_job(16 * 14);
        check_eq("ram_last", 64'(ram[WB + 63]), 64'h4F);
        check_eq("ram_first", 64'(ram[WB]), 64'h10);

        // saturation; config change and start while busy are ignored
        start_job(8'hF0, 1'b0);
        repeat (60) @(negedge clk);
        cfg_offset = 8'h01;
        cfg_mode   = 1'b1;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("cfg_hold", {arr_mode, arr_offset}, {1'b0, 8'hF0});
        wait_done(400);
        end_job(16 * 14);
        check_eq("ram_sat", 64'(ram[WB + 16]), 64'hFF);

        // darken, 50 extra WAIT cycles in chunk 5, arr_done pulse in FIRE
        stall_en  = 1'b1;
        glitch_en = 1'b1;
        start_job(8'h05, 1'b1);
        wait_done(600);
        end_job(16 * 14 + 50);
        stall_en  = 1'b0;
        glitch_en = 1'b0;

        // abort during a write of chunk 7, then restart from address 0
        start_job(8'h10, 1'b0);
        found = 1'b0;
        n = 0;
        while (!found && n < 400) begin
            @(negedge clk);
            if (chunk_idx == 8'd7 && mem_wr_en) found = 1'b1;
            n++;
        end
        check_eq("abort_reached", 64'(found), 64'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("abort_outs", outs_all, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_eq("abort_hold", outs_all, 64'd0);
        rst = 1'b1;
        start_job(8'h20, 1'b0);
        wait_done(400);
        end_job(16 * 14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
